pacman_life_manager: RTL and testbench

//  Round/lives controller directly downstream of the game-logic top.

---
 rtl/pacman_life_manager.sv | 139 +++++++++++++
 tb/tb_pacman_life_manager.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pacman_life_manager.sv
// Round/lives controller: start-button synchroniser, lives count, READY/DYING hold timers,
// game-over state, and the freeze / sprite_rst / death_pulse strobes for the sprite logic.
module pacman_life_manager #(
   parameter int unsigned LIVES_INIT       = 3,
   parameter int unsigned READY_HOLD_TICKS = 4,
   parameter int unsigned DEATH_HOLD_TICKS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start_btn,
   input  logic       pacman_is_dead,
   output logic       freeze,
   output logic       sprite_rst,
   output logic       death_pulse,
   output logic [2:0] lives,
   output logic       game_over,
   output logic [2:0] state
);

   localparam int unsigned CTR_MAX = (READY_HOLD_TICKS > DEATH_HOLD_TICKS) ?
                                     READY_HOLD_TICKS : DEATH_HOLD_TICKS;
   localparam int unsigned CTR_W   = $clog2(CTR_MAX + 1);
   localparam int unsigned LIVES_W = 3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_READY     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_DYING     = 3'd3,
      ST_RESPAWN   = 3'd4,
      ST_GAME_OVER = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [CTR_W-1:0]   ctr_q, ctr_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic               freeze_q, freeze_d;
   logic               sprite_rst_q, sprite_rst_d;
   logic               death_pulse_q, death_pulse_d;
   logic               game_over_q, game_over_d;
   logic               sync1_q, sync2_q, btn_prev_q;
   logic               press;

   // Press is the rising edge of the synchronised button, acted on at the third clock edge.
   assign press = sync2_q & ~btn_prev_q;

   always_comb begin
      state_d       = state_q;
      ctr_d         = ctr_q;
      lives_d       = lives_q;
      sprite_rst_d  = 1'b0;
      death_pulse_d = 1'b0;

      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (press) begin
               state_d      = ST_READY;
               lives_d      = LIVES_W'(LIVES_INIT);
               sprite_rst_d = 1'b1;
               ctr_d        = CTR_W'(READY_HOLD_TICKS);
            end
         end
         ST_READY: begin
            if (ctr_q != '0) begin
               if (tick) ctr_d = ctr_q - CTR_W'(1);
            end else if (!pacman_is_dead) begin
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (pacman_is_dead) begin
               state_d       = ST_DYING;
               lives_d       = lives_q - LIVES_W'(1);
               death_pulse_d = 1'b1;
               ctr_d         = CTR_W'(DEATH_HOLD_TICKS);
            end
         end
         ST_DYING: begin
            if (tick && ctr_q != '0) begin
               ctr_d = ctr_q - CTR_W'(1);
               if (ctr_q == CTR_W'(1)) begin
                  if (lives_q == '0) begin
                     state_d = ST_GAME_OVER;
                  end else begin
                     state_d      = ST_RESPAWN;
                     sprite_rst_d = 1'b1;
                  end
               end
            end
         end
         ST_RESPAWN: begin
            state_d = ST_READY;
            ctr_d   = CTR_W'(READY_HOLD_TICKS);
         end
         default: begin
            state_d = ST_IDLE;
            ctr_d   = '0;
         end
      endcase

      freeze_d    = (state_d != ST_PLAY);
      game_over_d = (state_d == ST_GAME_OVER);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         ctr_q         <= '0;
         lives_q       <= LIVES_W'(LIVES_INIT);
         freeze_q      <= 1'b1;
         sprite_rst_q  <= 1'b0;
         death_pulse_q <= 1'b0;
         game_over_q   <= 1'b0;
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         btn_prev_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         ctr_q         <= ctr_d;
         lives_q       <= lives_d;
         freeze_q      <= freeze_d;
         sprite_rst_q  <= sprite_rst_d;
         death_pulse_q <= death_pulse_d;
         game_over_q   <= game_over_d;
         sync1_q       <= start_btn;
         sync2_q       <= sync1_q;
         btn_prev_q    <= sync2_q;
      end
   end

   assign freeze      = freeze_q;
   assign sprite_rst  = sprite_rst_q;
   assign death_pulse = death_pulse_q;
   assign lives       = lives_q;
   assign game_over   = game_over_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pacman_life_manager.sv
// Directed bench for pacman_life_manager: expected values queued then popped against DUT outputs.
module tb_pacman_life_manager;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic       start_btn;
   logic       pacman_is_dead;
   logic       freeze;
   logic       sprite_rst;
   logic       death_pulse;
   logic [2:0] lives;
   logic       game_over;
   logic [2:0] state;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   pacman_life_manager #(
      .LIVES_INIT(3), .READY_HOLD_TICKS(4), .DEATH_HOLD_TICKS(16)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .start_btn(start_btn),
      .pacman_is_dead(pacman_is_dead), .freeze(freeze), .sprite_rst(sprite_rst),
      .death_pulse(death_pulse), .lives(lives), .game_over(game_over), .state(state)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] val);
      push_exp(tag, val);
      pop_cmp(obs);
   endtask

   // Advance n clock edges; land 1 time unit after the last edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_ticks(input int n);
      repeat (n) begin
         tick = 1'b1;
         step(1);
         tick = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; start_btn = 1'b0; pacman_is_dead = 1'b0;
      step(3);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_lives", 32'(lives), 32'd3);
      chk("rst_freeze", 32'(freeze), 32'd1);
      chk("rst_game_over", 32'(game_over), 32'd0);
      chk("rst_sprite_rst", 32'(sprite_rst), 32'd0);
      chk("rst_death_pulse", 32'(death_pulse), 32'd0);
      rst = 1'b0;
      step(1);

      // Start: button rises between edges, READY at the third edge
      start_btn = 1'b1;
      step(2);
      chk("start_edge2_state", 32'(state), 32'd0);
      step(1);
      chk("start_edge3_state", 32'(state), 32'd1);
      chk("start_sprite_rst", 32'(sprite_rst), 32'd1);
      step(1);
      chk("start_sprite_rst_end", 32'(sprite_rst), 32'd0);
      do_ticks(4);
      chk("ready_after_ticks", 32'(state), 32'd1);
      chk("ready_freeze", 32'(freeze), 32'd1);
      step(1);
      chk("play_state", 32'(state), 32'd2);
      chk("play_freeze", 32'(freeze), 32'd0);
      step(100);
      chk("held_btn_state", 32'(state), 32'd2);
      start_btn = 1'b0;

      // Kill: flag high for 10 cycles costs one life
      pacman_is_dead = 1'b1;
      step(1);
      chk("kill_state", 32'(state), 32'd3);
      chk("kill_lives", 32'(lives), 32'd2);
      chk("kill_death_pulse", 32'(death_pulse), 32'd1);
      step(1);
      chk("kill_pulse_end", 32'(death_pulse), 32'd0);
      step(8);
      pacman_is_dead = 1'b0;
      chk("kill_lives_once", 32'(lives), 32'd2);
      do_ticks(15);
      chk("dying_15_ticks", 32'(state), 32'd3);
      do_ticks(1);
      chk("respawn_state", 32'(state), 32'd4);
      chk("respawn_sprite_rst", 32'(sprite_rst), 32'd1);
      step(1);
      chk("respawn_to_ready", 32'(state), 32'd1);
      chk("respawn_sprite_end", 32'(sprite_rst), 32'd0);

      // Stuck collision through the READY countdown
      pacman_is_dead = 1'b1;
      do_ticks(4);
      step(5);
      chk("stuck_ready", 32'(state), 32'd1);
      chk("stuck_lives", 32'(lives), 32'd2);
      pacman_is_dead = 1'b0;
      step(1);
      chk("stuck_release_play", 32'(state), 32'd2);
      chk("stuck_release_lives", 32'(lives), 32'd2);

      // Second and third kills lead to game over
      pacman_is_dead = 1'b1;
      step(1);
      pacman_is_dead = 1'b0;
      chk("kill2_lives", 32'(lives), 32'd1);
      do_ticks(16);
      step(1);
      do_ticks(4);
      step(1);
      chk("kill2_back_play", 32'(state), 32'd2);
      pacman_is_dead = 1'b1;
      step(1);
      pacman_is_dead = 1'b0;
      chk("kill3_lives", 32'(lives), 32'd0);
      do_ticks(16);
      chk("game_over_state", 32'(state), 32'd5);
      chk("game_over_flag", 32'(game_over), 32'd1);
      chk("game_over_freeze", 32'(freeze), 32'd1);
      step(5);
      chk("game_over_hold", 32'(state), 32'd5);

      // New game from GAME_OVER
      start_btn = 1'b1;
      step(3);
      chk("restart_state", 32'(state), 32'd1);
      chk("restart_lives", 32'(lives), 32'd3);
      chk("restart_sprite_rst", 32'(sprite_rst), 32'd1);
      chk("restart_game_over", 32'(game_over), 32'd0);
      start_btn = 1'b0;
      do_ticks(4);
      step(1);
      pacman_is_dead = 1'b1;
      step(1);
      pacman_is_dead = 1'b0;
      chk("dying2_state", 32'(state), 32'd3);

      // No tick: DYING holds indefinitely
      step(1000);
      chk("no_tick_state", 32'(state), 32'd3);
      chk("no_tick_lives", 32'(lives), 32'd2);

      // Async reset between edges
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_lives", 32'(lives), 32'd3);
      chk("async_rst_freeze", 32'(freeze), 32'd1);
      chk("async_rst_death_pulse", 32'(death_pulse), 32'd0);
      step(2);
      rst = 1'b0;
      step(2);
      chk("post_rst_idle", 32'(state), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
